// File: rtl/msk_and_hpc2_pipe.sv
// HPC2 masked AND over W independent lanes with d shares and valid/ready flow control.
// Two enable-gated register stages; output is combinational from stage 2 only.
module msk_and_hpc2_pipe #(
  parameter int d = 2,
  parameter int W = 8,
  localparam int NP   = d*(d-1)/2,
  localparam int NRND = W*NP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [d*W-1:0]    ina,
  input  logic [d*W-1:0]    inb,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  input  logic [NRND-1:0]   rnd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [d*W-1:0]    out
);

  logic r_s1_vld, r_s2_vld;
  logic w_acc, w_adv2, w_in_rdy;

  // Second index m enumerates partners j != i in ascending order (j = m or m+1).
  logic [W-1:0] r_a1 [d];
  logic [W-1:0] r_b1 [d];
  logic [W-1:0] r_r1 [d][d-1];
  logic [W-1:0] r_v1 [d][d-1];
  logic [W-1:0] w_r_ord [d][d-1];
  logic [W-1:0] w_v_nxt [d][d-1];
  logic [W-1:0] r_p2 [d];
  logic [W-1:0] r_u2 [d][d-1];
  logic [W-1:0] r_w2 [d][d-1];
  logic [W-1:0] w_out [d];

  assign w_adv2    = r_s1_vld & (~r_s2_vld | out_ready);
  assign w_in_rdy  = ~r_s1_vld | w_adv2;
  assign w_acc     = in_valid & rnd_valid & w_in_rdy;
  assign in_ready  = w_in_rdy;
  assign rnd_ready = w_acc;
  assign out_valid = r_s2_vld;

  // Unpack the shared random r_ij (i<j) for each ordered pair and pre-mask b_j.
  for (genvar gi = 0; gi < d; gi++) begin : g_pair_i
    for (genvar gm = 0; gm < d-1; gm++) begin : g_pair_m
      localparam int J  = (gm < gi) ? gm : gm + 1;
      localparam int LO = (gi < J) ? gi : J;
      localparam int HI = (gi < J) ? J : gi;
      localparam int P  = LO*d - LO*(LO+1)/2 + (HI-1-LO);
      for (genvar gk = 0; gk < W; gk++) begin : g_bit
        assign w_r_ord[gi][gm][gk] = rnd[gk*NP + P];
      end
      assign w_v_nxt[gi][gm] = inb[J*W +: W] ^ w_r_ord[gi][gm];
    end
    assign out[gi*W +: W] = w_out[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      if (w_acc)       r_s1_vld <= 1'b1;
      else if (w_adv2) r_s1_vld <= 1'b0;
      if (w_adv2)         r_s2_vld <= 1'b1;
      else if (out_ready) r_s2_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < d; i++) begin
        r_a1[i] <= '0;
        r_b1[i] <= '0;
        for (int m = 0; m < d-1; m++) begin
          r_r1[i][m] <= '0;
          r_v1[i][m] <= '0;
        end
      end
    end else if (w_acc) begin
      for (int i = 0; i < d; i++) begin
        r_a1[i] <= ina[i*W +: W];
        r_b1[i] <= inb[i*W +: W];
        for (int m = 0; m < d-1; m++) begin
          r_r1[i][m] <= w_r_ord[i][m];
          r_v1[i][m] <= w_v_nxt[i][m];
        end
      end
    end
  end

  // Stage 2 holds while stalled so no glitchy recombination ever reaches the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < d; i++) begin
        r_p2[i] <= '0;
        for (int m = 0; m < d-1; m++) begin
          r_u2[i][m] <= '0;
          r_w2[i][m] <= '0;
        end
      end
    end else if (w_adv2) begin
      for (int i = 0; i < d; i++) begin
        r_p2[i] <= r_a1[i] & r_b1[i];
        for (int m = 0; m < d-1; m++) begin
          r_u2[i][m] <= ~r_a1[i] & r_r1[i][m];
          r_w2[i][m] <= r_a1[i] & r_v1[i][m];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < d; i++) begin
      w_out[i] = r_p2[i];
      for (int m = 0; m < d-1; m++) begin
        w_out[i] = w_out[i] ^ r_u2[i][m] ^ r_w2[i][m];
      end
    end
  end

endmodule

// File: tb/tb_msk_and_hpc2_pipe.sv
// Scoreboard bench: issue monitors push expected results on each accepted beat,
// output monitors pop and compare whenever a result is handed downstream.
module tb_msk_and_hpc2_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_in_valid, a_in_ready, a_rnd_valid, a_rnd_ready, a_out_valid, a_out_ready;
  logic [7:0] a_ina, a_inb, a_out;
  logic [3:0] a_rnd;

  logic        b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready, b_out_valid, b_out_ready;
  logic [23:0] b_ina, b_inb, b_out, b_rnd;

  msk_and_hpc2_pipe #(.d(2), .W(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ina(a_ina), .inb(a_inb), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready),
    .rnd(a_rnd), .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out)
  );

  msk_and_hpc2_pipe #(.d(3), .W(8)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ina(b_ina), .inb(b_inb), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
    .rnd(b_rnd), .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
  );

  typedef struct packed {
    logic [7:0] sh;
    logic [3:0] ab;
  } exp_t;

  exp_t       sb_a[$];
  logic [7:0] sb_b[$];
  exp_t       mon_e;
  logic [7:0] mon_b;
  int n_cmp = 0;
  int n_err = 0;
  int b_acc = 0;
  int b_rnd_pulses = 0;
  int b_out_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // HPC2 share equations for d=2: r01 = r10 = r.
  function automatic logic [7:0] model2(input logic [7:0] x, input logic [7:0] y,
                                        input logic [3:0] r);
    logic [3:0] a0, a1, b0, b1, o0, o1;
    a0 = x[3:0]; a1 = x[7:4]; b0 = y[3:0]; b1 = y[7:4];
    o0 = (a0 & b0) ^ (~a0 & r) ^ (a0 & (b1 ^ r));
    o1 = (a1 & b1) ^ (~a1 & r) ^ (a1 & (b0 ^ r));
    return {o1, o0};
  endfunction

  always @(negedge clk) begin
    if (!rst && a_in_valid && a_in_ready && a_rnd_valid)
      sb_a.push_back({model2(a_ina, a_inb, a_rnd),
                      (a_ina[7:4] ^ a_ina[3:0]) & (a_inb[7:4] ^ a_inb[3:0])});
    if (!rst && a_out_valid && a_out_ready) begin
      if (sb_a.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected_output: got 0x%0h expected none", a_out);
      end else begin
        mon_e = sb_a.pop_front();
        chk("a_shares", {24'd0, a_out}, {24'd0, mon_e.sh});
        chk("a_unmasked", {28'd0, a_out[7:4] ^ a_out[3:0]}, {28'd0, mon_e.ab});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_in_valid && b_in_ready && b_rnd_valid) begin
      sb_b.push_back((b_ina[7:0] ^ b_ina[15:8] ^ b_ina[23:16]) &
                     (b_inb[7:0] ^ b_inb[15:8] ^ b_inb[23:16]));
      b_acc++;
    end
    if (!rst && b_rnd_ready) b_rnd_pulses++;
    if (!rst && b_out_valid && b_out_ready) begin
      b_out_cnt++;
      if (sb_b.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_output: got 0x%0h expected none", b_out);
      end else begin
        mon_b = sb_b.pop_front();
        chk("b_unmasked", {24'd0, b_out[7:0] ^ b_out[15:8] ^ b_out[23:16]}, {24'd0, mon_b});
      end
    end
  end

  task automatic send_a(input logic [7:0] x, input logic [7:0] y, input logic [3:0] r,
                        output int waits);
    logic ok;
    a_ina = x; a_inb = y; a_rnd = r; a_in_valid = 1'b1; a_rnd_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk); #1;
      if (ok) break;
      waits++;
      if (waits > 40) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", waits);
        break;
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    a_out_ready = 1'b1;
    while ((sb_a.size() != 0 || a_out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL drain_a: got %0d pending expected 0", sb_a.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  int w, stall_sum, n, cnt, cyc;
  logic [3:0] ma, mb;

  initial begin
    rst = 1'b0;
    a_in_valid = 0; a_rnd_valid = 0; a_out_ready = 1; a_ina = 0; a_inb = 0; a_rnd = 0;
    b_in_valid = 0; b_rnd_valid = 0; b_out_ready = 1; b_ina = 0; b_inb = 0; b_rnd = 0;
    #1 rst = 1'b1;
    #11;
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_out", {24'd0, a_out}, 32'd0);
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_rnd_ready", {31'd0, a_rnd_ready}, 32'd0);
    chk("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: a=0xB, b=0x6, rnd=0xA -> shares {0xC,0xE}, unmasked 0x2.
    send_a(8'hE5, 8'h53, 4'hA, w);
    chk("t1_valid_t1", {31'd0, a_out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t1_valid_t2", {31'd0, a_out_valid}, 32'd1);
    chk("t1_out", {24'd0, a_out}, 32'h0000_00CE);
    chk("t1_unmasked", {28'd0, a_out[7:4] ^ a_out[3:0]}, 32'd2);
    drain_a();

    // Test 2: 16 back-to-back beats, outputs must come without bubbles.
    stall_sum = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          ma = 4'($urandom); mb = 4'($urandom);
          send_a({4'(i) ^ ma, ma}, {4'((i*5 + 3) & 15) ^ mb, mb}, 4'($urandom), w);
          stall_sum += w;
        end
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!a_out_valid && n < 40);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
          if (a_out_valid) cnt++;
          if (k < 15) @(negedge clk);
        end
      end
    join
    chk("t2_consecutive", cnt, 32'd16);
    chk("t2_in_stalls", stall_sum, 32'd0);
    drain_a();

    // Test 3: downstream stall with three beats offered.
    a_out_ready = 1'b0;
    send_a(8'h3C, 8'hA5, 4'h6, w);
    send_a(8'h71, 8'h9E, 4'h3, w);
    a_ina = 8'hD2; a_inb = 8'h4B; a_rnd = 4'hC; a_in_valid = 1'b1; a_rnd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_in_ready", {31'd0, a_in_ready}, 32'd0);
      chk("t3_out_valid", {31'd0, a_out_valid}, 32'd1);
      chk("t3_out_hold", {24'd0, a_out}, {24'd0, sb_a[0].sh});
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    send_a(8'hD2, 8'h4B, 4'hC, w);
    chk("t3_release_wait", w, 32'd0);
    drain_a();

    // Test 4: operands without randomness are not accepted.
    a_ina = 8'h96; a_inb = 8'hF0; a_rnd = 4'h5; a_in_valid = 1'b1; a_rnd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_rnd_ready", {31'd0, a_rnd_ready}, 32'd0);
      chk("t4_out_valid", {31'd0, a_out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    send_a(8'h96, 8'hF0, 4'h5, w);
    chk("t4_valid_t1", {31'd0, a_out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t4_valid_t2", {31'd0, a_out_valid}, 32'd1);
    drain_a();

    // Test 5: asynchronous reset with both stages full.
    a_out_ready = 1'b0;
    send_a(8'h5A, 8'hC3, 4'h9, w);
    send_a(8'hE1, 8'h2D, 4'h7, w);
    #3 rst = 1'b1;
    a_in_valid = 1'b1; a_rnd_valid = 1'b1;
    #1;
    chk("t5_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("t5_out", {24'd0, a_out}, 32'd0);
    chk("t5_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("t5_rnd_ready", {31'd0, a_rnd_ready}, 32'd1);
    a_in_valid = 1'b0;
    sb_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    send_a(8'h4E, 8'hB8, 4'hF, w);
    chk("t5_valid_t1", {31'd0, a_out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t5_valid_t2", {31'd0, a_out_valid}, 32'd1);
    drain_a();

    // Test 6: d=3, W=8, 1000 random beats with random stalls.
    cyc = 0;
    while (b_acc < 1000 && cyc < 20000) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_rnd_valid = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 9) < 7);
      b_ina = 24'($urandom); b_inb = 24'($urandom); b_rnd = 24'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    n = 0;
    while ((sb_b.size() != 0 || b_out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_accepted", b_acc, 32'd1000);
    chk("t6_outputs", b_out_cnt, 32'd1000);
    chk("t6_rnd_bits", b_rnd_pulses * 24, 32'd24000);
    chk("t6_pending", sb_b.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
